guess_scorer_ctrl: RTL and testbench
====================================

Name: guess_scorer_ctrl

Overview:
- Sequences one Mastermind game: latches the secret code, accepts player guesses, and scores each guess over multiple cycles into black/white peg counts.
- Counts attempts and raises the win/lose levels (gameOverW, gameOverL) that drive the gameMode FSM.
- Sits between the switch/key input logic and gameMode/HEX display drivers.

Parameters:
- NUM_PEGS, 4, pegs per code.
- NUM_COLORS, 6, legal colours 0..NUM_COLORS-1; each peg is 3 bits.
- MAX_GUESSES, 10, attempts allowed before loss.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE immediately.
- start  in  1  one-cycle pulse; begins a game.
- secret  in  3*NUM_PEGS  secret code; peg i at [3i+:3]; sampled on start.
- guess  in  3*NUM_PEGS  player guess, same packing.
- submit  in  1  one-cycle pulse (already debounced and edge-detected upstream).
- busy  out  1  high while scoring (SCORE_EXACT, SCORE_COLOR).
- result_valid  out  1  one-cycle pulse in REPORT.
- black_cnt  out  3  exact matches of last scored guess.
- white_cnt  out  3  colour-only matches of last scored guess.
- guess_num  out  4  accepted guesses this game.
- invalid_guess  out  1  one-cycle pulse when a submit is rejected.
- gameOverW  out  1  level; game won.
- gameOverL  out  1  level; game lost.

Behaviour:
- Reset: state IDLE; all outputs, counters and latched codes are 0. Reset mid-game or mid-scoring aborts with no result_valid.
- States: IDLE, WAIT_GUESS, SCORE_EXACT, SCORE_COLOR, REPORT, WIN, LOSE.
- IDLE:
  - start -> latch secret, clear guess_num/black_cnt/white_cnt, go to WAIT_GUESS.
  - A secret containing any peg >= NUM_COLORS -> start ignored, stay in IDLE.
- WAIT_GUESS, submit at edge k:
  - Any guess peg >= NUM_COLORS -> invalid_guess high the next cycle; guess not latched; guess_num unchanged; stay.
  - Otherwise latch guess, clear accumulators, go to SCORE_EXACT.
- SCORE_EXACT: NUM_PEGS cycles.
  - Position index p = 0..NUM_PEGS-1; black accumulates (secret[p]==guess[p]).
- SCORE_COLOR: NUM_COLORS cycles.
  - Colour index c = 0..NUM_COLORS-1.
  - total accumulates min(count of c in secret, count of c in guess); counts are combinational over NUM_PEGS comparators.
- Transition into REPORT (edge k+NUM_PEGS+NUM_COLORS; k+10 at defaults):
  - black_cnt <= black; white_cnt <= total - black; guess_num increments.
  - Counts saturate at NUM_PEGS by construction; white never negative.
- REPORT: result_valid high for exactly one cycle, then:
  - black_cnt==NUM_PEGS -> WIN (takes priority over loss on the final guess).
  - else guess_num==MAX_GUESSES -> LOSE.
  - else WAIT_GUESS.
- WIN: gameOverW=1, held. LOSE: gameOverL=1, held. Both are terminal until reset; start and submit are ignored.
- Ignored inputs:
  - submit outside WAIT_GUESS, including during scoring.
  - start outside IDLE.
  - start and submit in the same cycle in IDLE: start taken, submit dropped.
- black_cnt/white_cnt/guess_num hold their values between reports and in WIN/LOSE.

Decomposition:
- Package mm_pkg:
  - COLOR_W=3, color_t (logic [2:0]), default NUM_PEGS/NUM_COLORS/MAX_GUESSES constants.
  - State enum for this block.
- Sub-module peg_scorer: owns the latched secret/guess, index counters, the black and total accumulators, and a done flag.
- The controller FSM sequences peg_scorer through its passes and owns guess_num and the game-over levels.

Test Plan:
- Secret {1,2,3,4} (peg0..3), guess {1,2,3,4} submitted at edge k -> result_valid at cycle k+10, black=4, white=0, guess_num=1; gameOverW=1 from the next cycle, gameOverL=0.
- Secret {1,2,3,4}, guess {4,3,2,1} -> black=0, white=4. Then guess {1,1,2,2} -> black=1, white=1, guess_num=2.
- Secret {0,0,0,0}, ten submits of {5,5,5,5} -> each report black=0, white=0. After the 10th, gameOverL=1, guess_num=10. An 11th submit produces no result_valid.
- Guess {7,1,2,3} in WAIT_GUESS -> invalid_guess pulse, guess_num unchanged, no busy. A repeat submit during busy is ignored and only one result_valid occurs.
- Assert reset asynchronously mid-SCORE_COLOR -> all outputs 0 immediately, state IDLE. A following start with secret {2,2,5,0} is accepted.
- Final (10th) guess exactly correct -> gameOverW=1, gameOverL stays 0.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared types and defaults for the Mastermind guess scoring block.
// Pegs are packed 3 bits each, peg i at [3i+:3].
package mm_pkg;

  localparam int COLOR_W         = 3;
  localparam int CNT_W           = 3;
  localparam int DEF_NUM_PEGS    = 4;
  localparam int DEF_NUM_COLORS  = 6;
  localparam int DEF_MAX_GUESSES = 10;

  typedef logic [COLOR_W-1:0] color_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_GUESS,
    S_SCORE_EXACT,
    S_SCORE_COLOR,
    S_REPORT,
    S_WIN,
    S_LOSE
  } state_t;

  function automatic logic [CNT_W-1:0] cnt_min(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/peg_scorer.sv
// Scoring datapath: holds the latched secret and guess, walks positions for
// exact matches, then colours summing min(secret count, guess count).
module peg_scorer
  import mm_pkg::*;
#(
  parameter int NUM_PEGS   = DEF_NUM_PEGS,
  parameter int NUM_COLORS = DEF_NUM_COLORS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_secret,
  input  logic [COLOR_W*NUM_PEGS-1:0] secret,
  input  logic                        load_guess,
  input  logic [COLOR_W*NUM_PEGS-1:0] guess,
  input  logic                        exact_en,
  input  logic                        color_en,
  output logic                        exact_last,
  output logic                        done,
  output logic [CNT_W-1:0]            black,
  output logic [CNT_W-1:0]            total_sum
);

  localparam int PW = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1;
  localparam int CW = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1;

  logic [COLOR_W*NUM_PEGS-1:0] secret_q;
  logic [COLOR_W*NUM_PEGS-1:0] guess_q;
  logic [PW-1:0]               pos_idx;
  logic [CW-1:0]               col_idx;
  logic [CNT_W-1:0]            black_acc;
  logic [CNT_W-1:0]            total_acc;
  color_t                      secret_peg;
  color_t                      guess_peg;
  color_t                      cur_color;
  logic [CNT_W-1:0]            cnt_s;
  logic [CNT_W-1:0]            cnt_g;

  assign secret_peg = secret_q[COLOR_W*pos_idx +: COLOR_W];
  assign guess_peg  = guess_q[COLOR_W*pos_idx +: COLOR_W];
  assign cur_color  = COLOR_W'(col_idx);

  always_comb begin
    cnt_s = '0;
    cnt_g = '0;
    for (int i = 0; i < NUM_PEGS; i++) begin
      if (secret_q[COLOR_W*i +: COLOR_W] == cur_color) cnt_s = cnt_s + CNT_W'(1);
      if (guess_q[COLOR_W*i +: COLOR_W] == cur_color)  cnt_g = cnt_g + CNT_W'(1);
    end
  end

  // total_sum includes the current colour so the controller can report on the last step
  assign total_sum  = color_en ? (total_acc + cnt_min(cnt_s, cnt_g)) : total_acc;
  assign black      = black_acc;
  assign exact_last = (pos_idx == PW'(NUM_PEGS - 1));
  assign done       = color_en && (col_idx == CW'(NUM_COLORS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      secret_q  <= '0;
      guess_q   <= '0;
      pos_idx   <= '0;
      col_idx   <= '0;
      black_acc <= '0;
      total_acc <= '0;
    end else begin
      if (load_secret) secret_q <= secret;
      if (load_guess) begin
        guess_q   <= guess;
        pos_idx   <= '0;
        col_idx   <= '0;
        black_acc <= '0;
        total_acc <= '0;
      end
      if (exact_en) begin
        if (secret_peg == guess_peg) black_acc <= black_acc + CNT_W'(1);
        pos_idx <= exact_last ? '0 : pos_idx + PW'(1);
      end
      if (color_en) begin
        total_acc <= total_sum;
        col_idx   <= done ? '0 : col_idx + CW'(1);
      end
    end
  end

endmodule

// File: rtl/guess_scorer_ctrl.sv
// Mastermind game sequencer: IDLE (await start) | WAIT_GUESS (await submit) | SCORE_EXACT/
// SCORE_COLOR (scoring passes) | REPORT (result pulse) | WIN/LOSE (terminal until reset).
module guess_scorer_ctrl
  import mm_pkg::*;
#(
  parameter int NUM_PEGS    = DEF_NUM_PEGS,
  parameter int NUM_COLORS  = DEF_NUM_COLORS,
  parameter int MAX_GUESSES = DEF_MAX_GUESSES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [COLOR_W*NUM_PEGS-1:0] secret,
  input  logic [COLOR_W*NUM_PEGS-1:0] guess,
  input  logic                        submit,
  output logic                        busy,
  output logic                        result_valid,
  output logic [CNT_W-1:0]            black_cnt,
  output logic [CNT_W-1:0]            white_cnt,
  output logic [3:0]                  guess_num,
  output logic                        invalid_guess,
  output logic                        gameOverW,
  output logic                        gameOverL
);

  state_t           state;
  logic             secret_ok;
  logic             guess_ok;
  logic             load_secret;
  logic             load_guess;
  logic             exact_en;
  logic             color_en;
  logic             exact_last;
  logic             done;
  logic [CNT_W-1:0] black;
  logic [CNT_W-1:0] total_sum;

  always_comb begin
    secret_ok = 1'b1;
    guess_ok  = 1'b1;
    for (int i = 0; i < NUM_PEGS; i++) begin
      if (secret[COLOR_W*i +: COLOR_W] >= COLOR_W'(NUM_COLORS)) secret_ok = 1'b0;
      if (guess[COLOR_W*i +: COLOR_W] >= COLOR_W'(NUM_COLORS))  guess_ok  = 1'b0;
    end
  end

  assign load_secret = (state == S_IDLE) && start && secret_ok;
  assign load_guess  = (state == S_WAIT_GUESS) && submit && guess_ok;
  assign exact_en    = (state == S_SCORE_EXACT);
  assign color_en    = (state == S_SCORE_COLOR);

  peg_scorer #(
    .NUM_PEGS   (NUM_PEGS),
    .NUM_COLORS (NUM_COLORS)
  ) u_scorer (
    .clk         (clk),
    .reset       (reset),
    .load_secret (load_secret),
    .secret      (secret),
    .load_guess  (load_guess),
    .guess       (guess),
    .exact_en    (exact_en),
    .color_en    (color_en),
    .exact_last  (exact_last),
    .done        (done),
    .black       (black),
    .total_sum   (total_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      result_valid  <= 1'b0;
      black_cnt     <= '0;
      white_cnt     <= '0;
      guess_num     <= '0;
      invalid_guess <= 1'b0;
      gameOverW     <= 1'b0;
      gameOverL     <= 1'b0;
    end else begin
      result_valid  <= 1'b0;
      invalid_guess <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && secret_ok) begin
            state     <= S_WAIT_GUESS;
            guess_num <= '0;
            black_cnt <= '0;
            white_cnt <= '0;
          end
        end
        S_WAIT_GUESS: begin
          if (submit) begin
            if (!guess_ok) begin
              invalid_guess <= 1'b1;
            end else begin
              state <= S_SCORE_EXACT;
              busy  <= 1'b1;
            end
          end
        end
        S_SCORE_EXACT: begin
          if (exact_last) state <= S_SCORE_COLOR;
        end
        S_SCORE_COLOR: begin
          if (done) begin
            state        <= S_REPORT;
            busy         <= 1'b0;
            result_valid <= 1'b1;
            black_cnt    <= black;
            white_cnt    <= total_sum - black;
            guess_num    <= guess_num + 4'd1;
          end
        end
        S_REPORT: begin
          // a fully correct last guess is a win, not a loss
          if (black_cnt == CNT_W'(NUM_PEGS)) begin
            state     <= S_WIN;
            gameOverW <= 1'b1;
          end else if (guess_num == 4'(MAX_GUESSES)) begin
            state     <= S_LOSE;
            gameOverL <= 1'b1;
          end else begin
            state <= S_WAIT_GUESS;
          end
        end
        S_WIN, S_LOSE: begin
          state <= state;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_guess_scorer_ctrl.sv
// Directed bench for guess_scorer_ctrl with a result scoreboard checked at every negedge.
module tb_guess_scorer_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        submit = 1'b0;
  logic [11:0] secret = '0;
  logic [11:0] guess = '0;
  logic        busy;
  logic        result_valid;
  logic [2:0]  black_cnt;
  logic [2:0]  white_cnt;
  logic [3:0]  guess_num;
  logic        invalid_guess;
  logic        gameOverW;
  logic        gameOverL;

  typedef struct {
    logic [2:0] b;
    logic [2:0] w;
    logic [3:0] n;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic exp_v;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  guess_scorer_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .secret        (secret),
    .guess         (guess),
    .submit        (submit),
    .busy          (busy),
    .result_valid  (result_valid),
    .black_cnt     (black_cnt),
    .white_cnt     (white_cnt),
    .guess_num     (guess_num),
    .invalid_guess (invalid_guess),
    .gameOverW     (gameOverW),
    .gameOverL     (gameOverL)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] code(input int p0, input int p1, input int p2, input int p3);
    return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
  endfunction

  function automatic logic [31:0] outs();
    return 32'({busy, result_valid, black_cnt, white_cnt, guess_num,
                invalid_guess, gameOverW, gameOverL});
  endfunction

  // result_valid must appear exactly 10 edges after the accepted submit edge
  always @(negedge clk) begin
    if (!reset) begin
      exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
      check("result_valid", 32'(result_valid), 32'(exp_v));
      if (result_valid && sb.size() > 0) begin
        e = sb.pop_front();
        check("black_cnt", 32'(black_cnt), 32'(e.b));
        check("white_cnt", 32'(white_cnt), 32'(e.w));
        check("guess_num", 32'(guess_num), 32'(e.n));
        check("no_win_during_report", 32'(gameOverW), 0);
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset  = 1'b1;
    start  = 1'b0;
    submit = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_start(input logic [11:0] s);
    @(negedge clk);
    secret = s;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_submit(input logic [11:0] g, input bit push,
                           input int b, input int w, input int n);
    exp_t x;
    @(negedge clk);
    guess  = g;
    submit = 1'b1;
    if (push) begin
      x.b   = 3'(b);
      x.w   = 3'(w);
      x.n   = 4'(n);
      x.cyc = cyc + 11;
      sb.push_back(x);
    end
    @(negedge clk);
    submit = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(sb.size()), 0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    check("reset_outputs", outs(), 0);
    reset = 1'b0;

    // exact guess on the first attempt wins
    do_start(code(1, 2, 3, 4));
    check("idle_start_no_busy", 32'(busy), 0);
    do_submit(code(1, 2, 3, 4), 1, 4, 0, 1);
    drain();
    check("win_level", 32'(gameOverW), 1);
    check("win_no_lose", 32'(gameOverL), 0);
    do_submit(code(1, 2, 3, 4), 0, 0, 0, 0);
    repeat (15) @(negedge clk);
    check("win_guess_num_held", 32'(guess_num), 1);
    check("win_black_held", 32'(black_cnt), 4);

    // permutation, repeated submit during busy, invalid colour, duplicates
    apply_reset();
    do_start(code(1, 2, 3, 4));
    do_submit(code(4, 3, 2, 1), 1, 0, 4, 1);
    repeat (3) @(negedge clk);
    check("busy_while_scoring", 32'(busy), 1);
    do_submit(code(1, 2, 3, 4), 0, 0, 0, 0);
    drain();
    do_submit(code(7, 1, 2, 3), 0, 0, 0, 0);
    check("invalid_pulse", 32'(invalid_guess), 1);
    check("invalid_no_busy", 32'(busy), 0);
    @(negedge clk);
    check("invalid_one_cycle", 32'(invalid_guess), 0);
    check("invalid_guess_num", 32'(guess_num), 1);
    do_submit(code(1, 1, 2, 2), 1, 1, 1, 2);
    drain();
    check("white_held", 32'(white_cnt), 1);

    // ten misses lose; an eleventh submit is ignored
    apply_reset();
    do_start(code(0, 0, 0, 0));
    for (int i = 1; i <= 10; i++) begin
      do_submit(code(5, 5, 5, 5), 1, 0, 0, i);
      drain();
    end
    check("lose_level", 32'(gameOverL), 1);
    check("lose_no_win", 32'(gameOverW), 0);
    check("lose_guess_num", 32'(guess_num), 10);
    do_submit(code(5, 5, 5, 5), 0, 0, 0, 0);
    repeat (15) @(negedge clk);
    check("lose_guess_num_held", 32'(guess_num), 10);

    // asynchronous reset in the colour pass aborts with no report
    apply_reset();
    do_start(code(1, 2, 3, 4));
    do_submit(code(1, 2, 3, 4), 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("async_reset_outputs", outs(), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    do_start(code(6, 0, 0, 0));
    do_submit(code(0, 0, 0, 0), 0, 0, 0, 0);
    check("bad_secret_ignored", 32'(busy), 0);
    @(negedge clk);
    secret = code(2, 2, 5, 0);
    guess  = code(2, 2, 5, 0);
    start  = 1'b1;
    submit = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    submit = 1'b0;
    check("start_wins_over_submit", 32'(busy), 0);
    @(negedge clk);
    check("submit_dropped", 32'(busy), 0);
    do_submit(code(2, 2, 5, 0), 1, 4, 0, 1);
    drain();
    check("restart_win", 32'(gameOverW), 1);

    // correct on the final attempt is a win, not a loss
    apply_reset();
    do_start(code(3, 1, 4, 0));
    for (int i = 1; i <= 9; i++) begin
      do_submit(code(5, 5, 5, 5), 1, 0, 0, i);
      drain();
    end
    do_submit(code(3, 1, 4, 0), 1, 4, 0, 10);
    drain();
    repeat (3) @(negedge clk);
    check("last_guess_win", 32'(gameOverW), 1);
    check("last_guess_no_lose", 32'(gameOverL), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
